// File: rtl/div_pkg.sv
// Shared widths and stage-register layout for the divider / multiplier pair.
package div_pkg;

  localparam int DIVIDENDLEN = 16;
  localparam int DIVISORLEN  = 8;
  localparam int DATAPATHLEN = DIVIDENDLEN + DIVISORLEN;
  localparam int PRODLEN     = DATAPATHLEN;

  // One pipeline slot. acc is full precision, so quotient*divisor+remainder never wraps.
  typedef struct packed {
    logic                   valid;
    logic                   rem_err;
    logic [PRODLEN-1:0]     acc;
    logic [DIVIDENDLEN-1:0] quotient;
    logic [DIVISORLEN-1:0]  divisor;
  } stage_t;

endpackage

// File: rtl/pipelined_multiplier_slice.sv
// One conditional shift-add step: adds divisor<<SHIFT when this quotient bit is set.
module multiplierslice
  import div_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [PRODLEN-1:0]    acc_in,
  input  logic                  qbit,
  input  logic [DIVISORLEN-1:0] divisor,
  output logic [PRODLEN-1:0]    acc_out
);

  logic [PRODLEN-1:0] addend;

  // Zero-extend the divisor before shifting so the top bits are never lost.
  always_comb begin
    addend = '0;
    if (qbit) addend = PRODLEN'(divisor) << SHIFT;
    acc_out = acc_in + addend;
  end

endmodule

// File: rtl/pipelined_multiplier.sv
// Pipelined reconstruction of dividend = quotient*divisor + remainder.
// One registered stage per quotient bit, MSB first, with a single global stall.
//
// Handshake: a transfer happens on a clock edge where valid && ready are both high.
// The producer holds its payload stable while valid && !ready; ready never depends
// on valid. Here in_ready = !out_valid || out_ready, so the whole pipe advances
// together or holds together.
//
// The stage layout comes from div_pkg::stage_t, so the width parameters are expected
// to stay at the package values.
module pipelined_multiplier #(
  parameter int DIVIDENDLEN = div_pkg::DIVIDENDLEN,
  parameter int DIVISORLEN  = div_pkg::DIVISORLEN
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DIVIDENDLEN-1:0]         quotient,
  input  logic [DIVISORLEN-1:0]          divisor,
  input  logic [DIVISORLEN-1:0]          remainder,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DIVIDENDLEN+DIVISORLEN-1:0] product,
  output logic [DIVIDENDLEN-1:0]         dividend,
  output logic                           overflow,
  output logic                           rem_err
);

  import div_pkg::*;

  localparam int N = DIVIDENDLEN;
  localparam int PLEN = DIVIDENDLEN + DIVISORLEN;

  stage_t            stage_q   [N];
  stage_t            stage_d   [N];
  logic [PLEN-1:0]   acc_next  [N];
  logic [PLEN-1:0]   remainder_ext;
  logic              advance;

  assign advance       = !stage_q[N-1].valid || out_ready;
  assign in_ready      = advance;
  assign remainder_ext = PLEN'(remainder);

  // Stage 0 starts from the remainder and folds in the quotient MSB.
  multiplierslice #(.SHIFT(N-1)) u_slice0 (
    .acc_in  (remainder_ext),
    .qbit    (quotient[N-1]),
    .divisor (divisor),
    .acc_out (acc_next[0])
  );

  for (genvar k = 1; k < N; k++) begin : g_slice
    multiplierslice #(.SHIFT(N-1-k)) u_slice (
      .acc_in  (stage_q[k-1].acc),
      .qbit    (stage_q[k-1].quotient[N-1-k]),
      .divisor (stage_q[k-1].divisor),
      .acc_out (acc_next[k])
    );
  end

  // Next value of every stage: predecessor's slot with the accumulated sum replaced.
  always_comb begin
    stage_d[0].valid    = in_valid;
    stage_d[0].rem_err  = (remainder >= divisor);
    stage_d[0].acc      = acc_next[0];
    stage_d[0].quotient = quotient;
    stage_d[0].divisor  = divisor;
    for (int k = 1; k < N; k++) begin
      stage_d[k]     = stage_q[k-1];
      stage_d[k].acc = acc_next[k];
    end
  end

  // Stage registers: cleared on reset, all advance together or all hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N; k++) stage_q[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < N; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign out_valid = stage_q[N-1].valid;
  assign product   = stage_q[N-1].acc;
  assign dividend  = stage_q[N-1].acc[N-1:0];
  assign overflow  = |stage_q[N-1].acc[PLEN-1:N];
  assign rem_err   = stage_q[N-1].rem_err;

endmodule
